// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared state encoding and counter sizing for button_conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        HELD       = 3'd2,
        REPEAT     = 3'd3,
        DB_RELEASE = 3'd4
    } btn_state_t;

    // Width needed to hold the largest terminal count of any timer phase.
    function automatic int cnt_w(input int db_ticks, input int rpt_delay, input int rpt_rate);
        int m;
        m = db_ticks;
        if (rpt_delay > m) m = rpt_delay;
        if (rpt_rate > m)  m = rpt_rate;
        return $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_channel
// Description : One button: 2-flop synchronizer, debounce FSM, auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module button_channel
    import button_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 2,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic repeat_en,
    output logic pulse,
    output logic held
);

    localparam int c_cnt_w = cnt_w(DEBOUNCE_TICKS, REPEAT_DELAY, REPEAT_RATE);

    localparam logic [c_cnt_w-1:0] c_zero       = '0;
    localparam logic [c_cnt_w-1:0] c_one        = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_db_last    = c_cnt_w'(DEBOUNCE_TICKS - 1);
    localparam logic [c_cnt_w-1:0] c_delay_last = c_cnt_w'(REPEAT_DELAY - 1);
    localparam logic [c_cnt_w-1:0] c_rate_last  = c_cnt_w'(REPEAT_RATE - 1);

    logic               r_s1;
    logic               r_s2;
    btn_state_t         r_state;
    btn_state_t         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               r_pulse;
    logic               w_pulse_next;
    logic               r_held;
    logic               w_held_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= c_zero;
            r_pulse <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_s1    <= raw;
            r_s2    <= r_s1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_pulse <= w_pulse_next;
            r_held  <= w_held_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pulse_next = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_s2) begin
                    w_state_next = DB_PRESS;
                    w_cnt_next   = c_one;
                end
            end
            DB_PRESS: begin
                if (!r_s2) begin
                    w_state_next = IDLE;
                    w_cnt_next   = c_zero;
                end else if (r_cnt == c_db_last) begin
                    w_state_next = HELD;
                    w_cnt_next   = c_zero;
                    w_pulse_next = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + c_one;
                end
            end
            HELD: begin
                if (!r_s2) begin
                    w_state_next = DB_RELEASE;
                    w_cnt_next   = c_one;
                end else if (repeat_en && (r_cnt == c_delay_last)) begin
                    w_state_next = REPEAT;
                    w_cnt_next   = c_zero;
                    w_pulse_next = 1'b1;
                end else if (r_cnt != c_delay_last) begin
                    // Stops at the terminal count so enabling repeat later fires at once.
                    w_cnt_next   = r_cnt + c_one;
                end
            end
            REPEAT: begin
                if (!r_s2) begin
                    w_state_next = DB_RELEASE;
                    w_cnt_next   = c_one;
                end else if (!repeat_en) begin
                    w_state_next = HELD;
                    w_cnt_next   = c_zero;
                end else if (r_cnt == c_rate_last) begin
                    w_cnt_next   = c_zero;
                    w_pulse_next = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + c_one;
                end
            end
            DB_RELEASE: begin
                if (r_s2) begin
                    w_state_next = HELD;
                    w_cnt_next   = c_zero;
                end else if (r_cnt == c_db_last) begin
                    w_state_next = IDLE;
                    w_cnt_next   = c_zero;
                end else begin
                    w_cnt_next   = r_cnt + c_one;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = c_zero;
            end
        endcase
    end

    assign w_held_next = (w_state_next == HELD) || (w_state_next == REPEAT) ||
                         (w_state_next == DB_RELEASE);

    assign pulse = r_pulse;
    assign held  = r_held;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : NUM_BTN independent debounced/auto-repeat button channels.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BTN        = 5,
    parameter int DEBOUNCE_TICKS = 2,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [NUM_BTN-1:0] repeat_en,
    output logic [NUM_BTN-1:0] pulse,
    output logic [NUM_BTN-1:0] held,
    output logic               pulse_any
);

    generate
        for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
            button_channel #(
                .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_RATE    (REPEAT_RATE)
            ) u_channel (
                .clk       (clk),
                .reset     (reset),
                .raw       (btn_raw[g]),
                .repeat_en (repeat_en[g]),
                .pulse     (pulse[g]),
                .held      (held[g])
            );
        end
    endgenerate

    // Built only from channel flops, so it is glitch-free and aligned with pulse.
    assign pulse_any = |pulse;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed self-checking bench for button_conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int NUM_BTN = 5;

    logic               clk;
    logic               reset;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] repeat_en;
    logic [NUM_BTN-1:0] pulse;
    logic [NUM_BTN-1:0] held;
    logic               pulse_any;

    int vectors;
    int miscompares;

    button_conditioner #(
        .NUM_BTN        (NUM_BTN),
        .DEBOUNCE_TICKS (2),
        .REPEAT_DELAY   (50),
        .REPEAT_RATE    (10)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .repeat_en (repeat_en),
        .pulse     (pulse),
        .held      (held),
        .pulse_any (pulse_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One active edge with current inputs; outputs are stable 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        btn_raw   = '0;
        repeat_en = '0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        btn_raw   = '1;
        repeat_en = '1;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if ({pulse, held, pulse_any} !== 11'b0) begin
                miscompares++;
                $display("FAIL reset cyc %0d: pulse=%b held=%b any=%b expected all 0",
                         i, pulse, held, pulse_any);
            end
        end
        btn_raw   = '0;
        repeat_en = '0;
        tick();
        reset = 1'b0;
        idle(6);
        vectors++;
        if ({pulse, held, pulse_any} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset idle: pulse=%b held=%b any=%b expected all 0",
                     pulse, held, pulse_any);
        end
    endtask

    task automatic test_clean_press();
        logic [NUM_BTN-1:0] ep;
        logic [NUM_BTN-1:0] eh;
        for (int i = 0; i < 30; i++) begin
            btn_raw = (i < 20) ? 5'b00001 : 5'b00000;
            tick();
            ep = (i == 3) ? 5'b00001 : 5'b00000;
            eh = (i >= 3 && i <= 22) ? 5'b00001 : 5'b00000;
            vectors++;
            if (pulse !== ep || pulse_any !== (i == 3)) begin
                miscompares++;
                $display("FAIL clean_press pulse edge %0d: pulse=%b any=%b expected %b",
                         i, pulse, pulse_any, ep);
            end
            vectors++;
            if (held !== eh) begin
                miscompares++;
                $display("FAIL clean_press held edge %0d: held=%b expected %b", i, held, eh);
            end
        end
        idle(6);
    endtask

    task automatic test_bounce();
        int n_pulse;
        int first_edge;
        int held_seen;
        n_pulse    = 0;
        first_edge = -1;
        for (int i = 0; i < 25; i++) begin
            btn_raw = '0;
            btn_raw[1] = (i == 0 || i == 2 || (i >= 4 && i < 15));
            tick();
            if (pulse[1]) begin
                n_pulse++;
                if (first_edge < 0) first_edge = i;
            end
        end
        vectors++;
        if (n_pulse != 1 || first_edge != 7) begin
            miscompares++;
            $display("FAIL bounce: %0d pulses first at edge %0d, expected 1 at edge 7",
                     n_pulse, first_edge);
        end
        vectors++;
        if (held !== 5'b0) begin
            miscompares++;
            $display("FAIL bounce held after release: held=%b expected 00000", held);
        end
        idle(6);
        n_pulse   = 0;
        held_seen = 0;
        for (int i = 0; i < 30; i++) begin
            btn_raw = '0;
            btn_raw[1] = (i % 5 == 0);
            tick();
            if (pulse[1]) n_pulse++;
            if (held[1])  held_seen++;
        end
        vectors++;
        if (n_pulse != 0 || held_seen != 0) begin
            miscompares++;
            $display("FAIL glitch: %0d pulses, held high %0d cycles, expected 0 and 0",
                     n_pulse, held_seen);
        end
        idle(6);
    endtask

    task automatic test_auto_repeat();
        logic [NUM_BTN-1:0] ep;
        int n_pulse;
        n_pulse      = 0;
        repeat_en    = 5'b00100;
        for (int i = 0; i < 110; i++) begin
            btn_raw = (i < 100) ? 5'b00100 : 5'b00000;
            tick();
            ep = (i == 3 || i == 53 || i == 63 || i == 73 || i == 83 || i == 93)
                 ? 5'b00100 : 5'b00000;
            if (pulse[2]) n_pulse++;
            vectors++;
            if (pulse !== ep) begin
                miscompares++;
                $display("FAIL auto_repeat edge %0d: pulse=%b expected %b", i, pulse, ep);
            end
        end
        vectors++;
        if (n_pulse != 6) begin
            miscompares++;
            $display("FAIL auto_repeat count: %0d pulses expected 6", n_pulse);
        end
        idle(6);
    endtask

    task automatic test_repeat_disabled();
        logic [NUM_BTN-1:0] ep;
        logic [NUM_BTN-1:0] eh;
        repeat_en = '0;
        for (int i = 0; i < 210; i++) begin
            btn_raw = (i < 200) ? 5'b00100 : 5'b00000;
            tick();
            ep = (i == 3) ? 5'b00100 : 5'b00000;
            eh = (i >= 3 && i <= 202) ? 5'b00100 : 5'b00000;
            vectors++;
            if (pulse !== ep || held !== eh) begin
                miscompares++;
                $display("FAIL repeat_disabled edge %0d: pulse=%b held=%b expected %b %b",
                         i, pulse, held, ep, eh);
            end
        end
        idle(6);
    endtask

    task automatic test_release_bounce();
        logic [NUM_BTN-1:0] ep;
        logic [NUM_BTN-1:0] eh;
        for (int i = 0; i < 22; i++) begin
            btn_raw = (i < 10 || i == 11) ? 5'b00001 : 5'b00000;
            tick();
            ep = (i == 3) ? 5'b00001 : 5'b00000;
            eh = (i >= 3 && i <= 14) ? 5'b00001 : 5'b00000;
            vectors++;
            if (pulse !== ep || held !== eh) begin
                miscompares++;
                $display("FAIL release_bounce edge %0d: pulse=%b held=%b expected %b %b",
                         i, pulse, held, ep, eh);
            end
        end
        idle(6);
    endtask

    task automatic test_simultaneous();
        logic [NUM_BTN-1:0] ep;
        int n_any;
        n_any = 0;
        for (int i = 0; i < 20; i++) begin
            btn_raw = (i < 15) ? 5'b11000 : 5'b00000;
            tick();
            ep = (i == 3) ? 5'b11000 : 5'b00000;
            if (pulse_any) n_any++;
            vectors++;
            if (pulse !== ep || pulse_any !== (i == 3)) begin
                miscompares++;
                $display("FAIL simultaneous edge %0d: pulse=%b any=%b expected %b",
                         i, pulse, pulse_any, ep);
            end
        end
        vectors++;
        if (n_any != 1) begin
            miscompares++;
            $display("FAIL simultaneous pulse_any count: %0d expected 1", n_any);
        end
        idle(6);
    endtask

    task automatic test_reset_mid_hold();
        logic [NUM_BTN-1:0] ep;
        repeat_en = 5'b00100;
        btn_raw   = 5'b00100;
        for (int i = 0; i < 63; i++) tick();
        vectors++;
        if (held !== 5'b00100) begin
            miscompares++;
            $display("FAIL mid_hold pre-reset held=%b expected 00100", held);
        end
        // Edge 63 would carry a repeat pulse; reset must suppress it.
        reset = 1'b1;
        tick();
        vectors++;
        if ({pulse, held, pulse_any} !== 11'b0) begin
            miscompares++;
            $display("FAIL mid_hold reset: pulse=%b held=%b any=%b expected all 0",
                     pulse, held, pulse_any);
        end
        tick();
        reset = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            ep = (j == 4) ? 5'b00100 : 5'b00000;
            vectors++;
            if (pulse !== ep) begin
                miscompares++;
                $display("FAIL mid_hold restart edge +%0d: pulse=%b expected %b", j, pulse, ep);
            end
            vectors++;
            if (held[2] !== (j >= 4)) begin
                miscompares++;
                $display("FAIL mid_hold restart held edge +%0d: held=%b expected %b",
                         j, held[2], (j >= 4));
            end
        end
        idle(8);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        btn_raw     = '0;
        repeat_en   = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_repeat_disabled();
        test_release_bounce();
        test_simultaneous();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
